// File: rtl/sampled_pkg.sv
// rtl/sampled_pkg.sv - shared types, limits and edge helpers for the sampled-value tracker
//
// Purpose: common definitions imported by sampled_shift_reg and sampled_value_tracker.
//   DEPTH_MIN  : smallest legal history depth (newest + one previous sample).
//   VEC_W_MAX  : widest monitored vector the edge helper handles.
//   fill_cnt_t : fill-count type used for saturating arithmetic.
//   fill_next  : saturating fill increment.
//   edge_bits  : per-bit rose/fell decode of two samples.
// Ports: none (package).
package sampled_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int VEC_W_MAX = 64;

  typedef logic [7:0] fill_cnt_t;

  // Increment that stops at lim; never wraps.
  function automatic fill_cnt_t fill_next(input fill_cnt_t cur, input fill_cnt_t lim);
    return (cur >= lim) ? cur : cur + fill_cnt_t'(1);
  endfunction

  // rising=1 gives cur & ~prev (rose), rising=0 gives ~cur & prev (fell).
  // Callers zero-extend narrower vectors in and truncate the result back.
  function automatic logic [VEC_W_MAX-1:0] edge_bits(input logic [VEC_W_MAX-1:0] cur,
                                                     input logic [VEC_W_MAX-1:0] prev,
                                                     input logic                 rising);
    return rising ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/sampled_shift_reg.sv
// rtl/sampled_shift_reg.sv - enabled history shift register with saturating fill counter
//
// Purpose: holds HIST samples of d_i (entry 0 newest) and counts how many are valid.
// Ports:
//   clk     in   sampling clock, rising edge
//   rst     in   asynchronous active-high reset; clears history and fill
//   en      in   1 = shift in d_i and bump fill, 0 = hold
//   d_i     in   WIDTH sample input
//   hist_o  out  HIST x WIDTH history, entry 0 newest
//   fill_o  out  FILL_W valid-entry count, saturates at HIST
module sampled_shift_reg
  import sampled_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HIST   = 4,
  parameter int FILL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            d_i,
  output logic [HIST-1:0][WIDTH-1:0]  hist_o,
  output logic [FILL_W-1:0]           fill_o
);

  logic [HIST-1:0][WIDTH-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]          fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (en) begin
      hist_d[0] = d_i;
      for (int i = 1; i < HIST; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      fill_d = FILL_W'(fill_next(fill_cnt_t'(fill_q), fill_cnt_t'(HIST)));
    end
  end

  // The flop only ever sees the value d_i held before the edge; nothing
  // downstream reads d_i directly, so checkers cannot race a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/sampled_value_tracker.sv
// rtl/sampled_value_tracker.sv - registered sampled-value history with $past/$rose/$fell/$stable/$changed decodes
//
// Purpose: keeps a history of sig_i sampled on enabled edges and presents the
// pre-edge values checker logic needs. Every output decodes registered state only.
// Build option: SAMPLED_PAST_EN adds past_sel_i/past_o/past_valid_o and keeps the
// full DEPTH history; without it history is 2 entries and fill saturates at 2.
// Ports:
//   clk           in   sampling clock
//   rst           in   asynchronous active-high reset
//   en            in   sample enable; 0 holds history and fill
//   sig_i         in   WIDTH monitored vector
//   past_sel_i    in   history index k (SAMPLED_PAST_EN only)
//   sampled_o     out  newest sample
//   past_o        out  hist[k], 0 when k is out of range (SAMPLED_PAST_EN only)
//   past_valid_o  out  fill > k (SAMPLED_PAST_EN only)
//   rose_o        out  per-bit hist[0] & ~hist[1]
//   fell_o        out  per-bit ~hist[0] & hist[1]
//   stable_o      out  hist[0] == hist[1] with at least two samples
//   changed_o     out  hist[0] != hist[1] with at least two samples
//   fill_o        out  number of valid history entries
module sampled_value_tracker
  import sampled_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           sig_i,
`ifdef SAMPLED_PAST_EN
  input  logic [$clog2(DEPTH)-1:0]   past_sel_i,
  output logic [WIDTH-1:0]           past_o,
  output logic                       past_valid_o,
`endif
  output logic [WIDTH-1:0]           sampled_o,
  output logic [WIDTH-1:0]           rose_o,
  output logic [WIDTH-1:0]           fell_o,
  output logic                       stable_o,
  output logic                       changed_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int FILL_W = $clog2(DEPTH + 1);
`ifdef SAMPLED_PAST_EN
  localparam int HIST   = DEPTH;
  localparam int SEL_W  = $clog2(DEPTH);
`else
  localparam int HIST   = DEPTH_MIN;
`endif

  logic [HIST-1:0][WIDTH-1:0] hist;
  logic [FILL_W-1:0]          fill;
  logic                       two_samples;

  sampled_shift_reg #(
    .WIDTH  (WIDTH),
    .HIST   (HIST),
    .FILL_W (FILL_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .d_i    (sig_i),
    .hist_o (hist),
    .fill_o (fill)
  );

  assign two_samples = (fill >= FILL_W'(DEPTH_MIN));

  assign sampled_o = hist[0];
  assign fill_o    = fill;

  // Not gated by fill: the first 1 after reset rises against the zeroed history.
  assign rose_o = WIDTH'(edge_bits(VEC_W_MAX'(hist[0]), VEC_W_MAX'(hist[1]), 1'b1));
  assign fell_o = WIDTH'(edge_bits(VEC_W_MAX'(hist[0]), VEC_W_MAX'(hist[1]), 1'b0));

  assign stable_o  = two_samples && (hist[0] == hist[1]);
  assign changed_o = two_samples && (hist[0] != hist[1]);

`ifdef SAMPLED_PAST_EN
  // Loop compare rather than a direct index so k >= DEPTH (non-power-of-2
  // DEPTH) simply selects nothing and leaves past_o at 0.
  always_comb begin
    past_o = '0;
    for (int i = 0; i < HIST; i++) begin
      if (past_sel_i == SEL_W'(i)) begin
        past_o = hist[i];
      end
    end
  end

  assign past_valid_o = (32'(fill) > 32'(past_sel_i));
`endif

endmodule

// File: tb/tb_sampled_value_tracker.sv
// tb/tb_sampled_value_tracker.sv - directed self-checking bench for sampled_value_tracker
module tb_sampled_value_tracker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SAMPLED_PAST_EN
  localparam int HIST_EXP = DEPTH;
`else
  localparam int HIST_EXP = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] sampled, rose, fell;
  logic             stable, changed;
  logic [2:0]       fill;
`ifdef SAMPLED_PAST_EN
  logic [1:0]       past_sel;
  logic [WIDTH-1:0] past;
  logic             past_valid;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sampled_value_tracker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_i        (sig),
`ifdef SAMPLED_PAST_EN
    .past_sel_i   (past_sel),
    .past_o       (past),
    .past_valid_o (past_valid),
`endif
    .sampled_o    (sampled),
    .rose_o       (rose),
    .fell_o       (fell),
    .stable_o     (stable),
    .changed_o    (changed),
    .fill_o       (fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [WIDTH-1:0] v);
    @(negedge clk);
    en  = e;
    sig = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sampled"}, 32'(sampled), 0);
    chk({tag, " rose"},    32'(rose),    0);
    chk({tag, " fell"},    32'(fell),    0);
    chk({tag, " stable"},  32'(stable),  0);
    chk({tag, " changed"}, 32'(changed), 0);
    chk({tag, " fill"},    32'(fill),    0);
`ifdef SAMPLED_PAST_EN
    chk({tag, " past"},       32'(past),       0);
    chk({tag, " past_valid"}, 32'(past_valid), 0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    sig = '0;
`ifdef SAMPLED_PAST_EN
    past_sel = 2'd0;
`endif
    #1 rst = 1'b1;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: 01, 01, 00
    step(1'b1, 8'h01);
    chk("s1e1 fill", 32'(fill), 1);
    chk("s1e1 sampled", 32'(sampled), 32'h01);
    chk("s1e1 rose", 32'(rose), 32'h01);
    chk("s1e1 stable", 32'(stable), 0);
    chk("s1e1 changed", 32'(changed), 0);
    step(1'b1, 8'h01);
    chk("s1e2 fill", 32'(fill), 2);
    chk("s1e2 stable", 32'(stable), 1);
    chk("s1e2 rose", 32'(rose), 0);
    chk("s1e2 changed", 32'(changed), 0);
    step(1'b1, 8'h00);
    chk("s1e3 fill", 32'(fill), (HIST_EXP >= 3) ? 3 : 2);
    chk("s1e3 fell", 32'(fell), 32'h01);
    chk("s1e3 changed", 32'(changed), 1);
    chk("s1e3 stable", 32'(stable), 0);

    // sig_i flips right after each edge: only the pre-edge value is ever visible.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2 == 0) ? 8'h00 : 8'h01);
      sig = ~sig;
      #1;
      chk("toggle sampled", 32'(sampled), (i % 2 == 0) ? 32'h00 : 32'h01);
    end

    // Load A0..A4
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i));
    chk("load sampled", 32'(sampled), 32'hA4);
    chk("load fill", 32'(fill), HIST_EXP);
    chk("load rose", 32'(rose), 32'h04);
    chk("load fell", 32'(fell), 32'h03);
    chk("load changed", 32'(changed), 1);
`ifdef SAMPLED_PAST_EN
    past_sel = 2'd3;
    #1;
    chk("load past3", 32'(past), 32'hA1);
    chk("load past3 valid", 32'(past_valid), 1);
`endif

    // en=0 while sig_i wanders: everything holds.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h10 + 8'(i * 3));
      chk("hold sampled", 32'(sampled), 32'hA4);
      chk("hold fill", 32'(fill), HIST_EXP);
`ifdef SAMPLED_PAST_EN
      chk("hold past3", 32'(past), 32'hA1);
`endif
    end

    // Async reset between edges clears at once.
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_all_zero("midrst");
    rst = 1'b0;
    step(1'b1, 8'h55);
    chk("postrst sampled", 32'(sampled), 32'h55);
    chk("postrst fill", 32'(fill), 1);
    chk("postrst stable", 32'(stable), 0);
    chk("postrst rose", 32'(rose), 32'h55);
`ifdef SAMPLED_PAST_EN
    past_sel = 2'd0;
    #1;
    chk("postrst past0", 32'(past), 32'h55);
    chk("postrst past0 valid", 32'(past_valid), 1);
    past_sel = 2'd1;
    #1;
    chk("postrst past1", 32'(past), 0);
    chk("postrst past1 valid", 32'(past_valid), 0);
`endif

    // Reset held across an enabled edge wins over en.
    @(negedge clk);
    en  = 1'b1;
    sig = 8'hFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst over en fill", 32'(fill), 0);
    chk("rst over en sampled", 32'(sampled), 0);
    rst = 1'b0;

    // Fill saturation from empty.
    for (int n = 1; n <= 6; n++) begin
      step(1'b1, 8'(n));
      chk("sat fill", 32'(fill), (n < HIST_EXP) ? n : HIST_EXP);
    end
    chk("sat stable", 32'(stable), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
